// File: rtl/black_to_red_stream_writer.sv
// Avalon-ST to ring-buffer packet writer: stores payload after a reserved header word,
// then commits the header and write pointer so the consumer only ever sees whole packets.
module black_to_red_stream_writer #(
  parameter int DEPTH   = 12500,
  parameter int ADDR_W  = 14,
  parameter int MAX_PKT = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       asi_data,
  input  logic              asi_valid,
  input  logic              asi_sop,
  input  logic              asi_eop,
  output logic              asi_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              pkt_done,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, HEADER, DROP} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] hdr_addr;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       len;
  logic              trunc;
  logic [31:0]       fsum, free;
  logic              room, acc, can_store, drop_hit;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Free space in words, one slot kept empty so wr_ptr == rd_ptr means empty.
  assign fsum      = 32'(rd_ptr) + 32'(DEPTH) - 32'(wr_ptr) - 32'd1;
  assign free      = (fsum >= 32'(DEPTH)) ? fsum - 32'(DEPTH) : fsum;
  assign room      = free >= 32'(MAX_PKT + 1);
  assign acc       = asi_valid & asi_ready;
  assign can_store = len < 16'(MAX_PKT);
  assign drop_hit  = acc & asi_eop &
                     (((state == IDLE) & asi_sop & ~room) | (state == DROP));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (acc && asi_sop) begin
          if (room) state_nx = asi_eop ? HEADER : PAYLOAD;
          else      state_nx = asi_eop ? IDLE : DROP;
        end
      end
      PAYLOAD: if (acc && asi_eop) state_nx = HEADER;
      HEADER:  state_nx = IDLE;
      DROP:    if (acc && asi_eop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    asi_ready      = (state != HEADER);
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = 4'hF;
    pkt_done       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (acc && asi_sop && room) begin
            mem_write     = 1'b1;
            mem_address   = wrap_inc(wr_ptr);
            mem_writedata = asi_data;
          end
        end
        PAYLOAD: begin
          if (acc && can_store) begin
            mem_write     = 1'b1;
            mem_address   = waddr;
            mem_writedata = asi_data;
          end
        end
        HEADER: begin
          mem_write     = 1'b1;
          mem_address   = hdr_addr;
          mem_writedata = {trunc, 15'b0, len};
          pkt_done      = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign mem_chipselect = mem_write;

  // waddr always holds the address the next stored payload word goes to.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      hdr_addr   <= '0;
      waddr      <= '0;
      len        <= '0;
      trunc      <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop_hit && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      case (state)
        IDLE: begin
          if (acc && asi_sop && room) begin
            hdr_addr <= wr_ptr;
            waddr    <= wrap_inc(wrap_inc(wr_ptr));
            len      <= 16'd1;
          end
        end
        PAYLOAD: begin
          if (acc) begin
            if (can_store) begin
              waddr <= wrap_inc(waddr);
              len   <= len + 16'd1;
            end else begin
              trunc <= 1'b1;
            end
          end
        end
        HEADER: begin
          wr_ptr <= waddr;
          trunc  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_black_to_red_stream_writer.sv
// Directed bench for black_to_red_stream_writer: captures memory writes and checks
// addresses, data, pointers and counters against hand-computed values.
module tb_black_to_red_stream_writer;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   asi_data;
  logic          asi_valid, asi_sop, asi_eop, asi_ready;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_writedata;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          pkt_done;
  logic [15:0]   drop_count;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int done_cnt, rdy_low, be_bad;

  black_to_red_stream_writer dut (
    .clk(clk), .reset(reset),
    .asi_data(asi_data), .asi_valid(asi_valid), .asi_sop(asi_sop), .asi_eop(asi_eop),
    .asi_ready(asi_ready),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .pkt_done(pkt_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write && mem_chipselect) begin
      wa_q.push_back(mem_address);
      wd_q.push_back(mem_writedata);
      if (mem_byteenable != 4'hF) be_bad++;
    end
    if (pkt_done) done_cnt++;
    if (!asi_ready && !reset) rdy_low++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    rdy_low  = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit mid_sop);
    for (int i = 0; i < n; i++) begin
      int t;
      asi_valid = 1'b1;
      asi_sop   = (i == 0) || (mid_sop && i == 1);
      asi_eop   = (i == n - 1);
      asi_data  = base + 32'(i);
      t = 0;
      while (!asi_ready && t < 100) begin step(); t++; end
      if (t >= 100) begin chk("ready_timeout", 64'(asi_ready), 64'd1); break; end
      step();
    end
    asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    repeat (3) step();
  endtask

  task automatic chk_w(input string tag, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, 64'(wa_q[idx]), 64'(a));
      chk({tag, "_data"}, 64'(wd_q[idx]), 64'(d));
    end else begin
      chk({tag, "_missing"}, 64'(wa_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    logic [AW-1:0] w0;
    reset = 1'b1; asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    asi_data = '0; rd_ptr = '0;
    done_cnt = 0; rdy_low = 0; be_bad = 0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_mem_write", 64'({mem_write, mem_chipselect}), 64'd0);
    chk("rst_ready", 64'(asi_ready), 64'd1);
    step();

    // 3-beat packet, with a spurious sop on beat 1
    clr(); rd_ptr = 0;
    send_pkt(3, 32'hA000_0000, 1'b1);
    chk("p3_nwr", 64'(wa_q.size()), 64'd4);
    chk_w("p3_w0", 0, 1, 32'hA000_0000);
    chk_w("p3_w1", 1, 2, 32'hA000_0001);
    chk_w("p3_w2", 2, 3, 32'hA000_0002);
    chk_w("p3_hdr", 3, 0, 32'h0000_0003);
    chk("p3_done", 64'(done_cnt), 64'd1);
    chk("p3_wr_ptr", 64'(wr_ptr), 64'd4);

    // single-beat packet
    clr(); rd_ptr = 4;
    send_pkt(1, 32'd5, 1'b0);
    chk("p1_nwr", 64'(wa_q.size()), 64'd2);
    chk_w("p1_w0", 0, 5, 32'd5);
    chk_w("p1_hdr", 1, 4, 32'd1);
    chk("p1_wr_ptr", 64'(wr_ptr), 64'd6);
    chk("p1_rdy_low", 64'(rdy_low), 64'd1);

    // stray non-sop beat in IDLE is discarded
    clr();
    asi_valid = 1'b1; asi_sop = 1'b0; asi_eop = 1'b1; asi_data = 32'hDEAD;
    step();
    asi_valid = 1'b0; asi_eop = 1'b0;
    repeat (2) step();
    chk("stray_nwr", 64'(wa_q.size()), 64'd0);
    chk("stray_wr_ptr", 64'(wr_ptr), 64'd6);

    // drop: free=99, then free=512 (single beat), then free=513 stored
    clr(); rd_ptr = 106;
    send_pkt(4, 32'hB000, 1'b0);
    chk("drop_nwr", 64'(wa_q.size()), 64'd0);
    chk("drop_cnt1", 64'(drop_count), 64'd1);
    chk("drop_wr_ptr", 64'(wr_ptr), 64'd6);
    rd_ptr = 519;
    send_pkt(1, 32'hB100, 1'b0);
    chk("drop512_nwr", 64'(wa_q.size()), 64'd0);
    chk("drop_cnt2", 64'(drop_count), 64'd2);
    rd_ptr = 520;
    send_pkt(2, 32'hC000, 1'b0);
    chk("fit513_nwr", 64'(wa_q.size()), 64'd3);
    chk_w("fit513_w0", 0, 7, 32'hC000);
    chk_w("fit513_hdr", 2, 6, 32'd2);
    chk("fit513_wr_ptr", 64'(wr_ptr), 64'd9);

    // oversize packet is truncated at MAX_PKT
    clr(); rd_ptr = 9;
    send_pkt(600, 32'h1000, 1'b0);
    chk("trunc_nwr", 64'(wa_q.size()), 64'd513);
    chk_w("trunc_last", 511, 521, 32'h1000 + 32'd511);
    chk_w("trunc_hdr", 512, 9, 32'h8000_0200);
    chk("trunc_wr_ptr", 64'(wr_ptr), 64'd522);

    // advance the ring to 12498 with back-to-back drained packets
    while (wr_ptr != 12498) begin
      int r, n;
      r = 12498 - int'(wr_ptr);
      n = (r >= 1027) ? 512 : (r > 513) ? 256 : r - 1;
      clr(); rd_ptr = wr_ptr;
      send_pkt(n, 32'h2000, 1'b0);
    end
    chk("adv_hdr_notrunc", 64'(wd_q[wd_q.size()-1][31]), 64'd0);

    // packet wrapping the ring end
    clr(); rd_ptr = 600;
    send_pkt(2, 32'hE000, 1'b0);
    chk("wrap_nwr", 64'(wa_q.size()), 64'd3);
    chk_w("wrap_w0", 0, 12499, 32'hE000);
    chk_w("wrap_w1", 1, 0, 32'hE001);
    chk_w("wrap_hdr", 2, 12498, 32'd2);
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'd1);

    // reset mid-packet
    clr(); rd_ptr = 1;
    for (int i = 0; i < 2; i++) begin
      asi_valid = 1'b1; asi_sop = (i == 0); asi_eop = 1'b0; asi_data = 32'hF000 + 32'(i);
      step();
    end
    asi_valid = 1'b0; asi_sop = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("mrst_drop", 64'(drop_count), 64'd0);
    chk("mrst_ready", 64'(asi_ready), 64'd1);
    step();
    repeat (2) step();
    chk("mrst_nwr", 64'(wa_q.size()), 64'd2);
    chk("mrst_done", 64'(done_cnt), 64'd0);
    clr(); rd_ptr = 0;
    w0 = wr_ptr;
    send_pkt(3, 32'h3000, 1'b0);
    chk("mrst_nwr2", 64'(wa_q.size()), 64'd4);
    chk_w("mrst_w0", 0, w0 + 1, 32'h3000);
    chk_w("mrst_hdr", 3, 0, 32'd3);
    chk("mrst_wr_ptr2", 64'(wr_ptr), 64'd4);
    chk("byteenable", 64'(be_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
